// File: rtl/hilo_mult_unit.sv
// HI/LO multiply unit: iterative radix-2 shift-add multiplier feeding the
// architectural HI/LO registers, with mfhi/mflo writeback muxing and hazard stall.
module hilo_mult_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enhilo_EX,
    input  logic [3:0]       alu_op,
    input  logic [1:0]       regsel_EX,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] writeback_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [5:0] LastCnt = 6'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 accept;
    logic                 signed_op;
    logic                 rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   product;

    // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
    always_comb begin
        signed_op = (alu_op == 4'b0110);
        rs_neg    = signed_op & rs_data[WIDTH-1];
        rt_neg    = signed_op & rt_data[WIDTH-1];
        rs_mag    = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_mag    = rt_neg ? (~rt_data + 1'b1) : rt_data;
        accept    = enhilo_EX && (state_q != StRun);
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        product   = neg_q ? (~acc_step + 1'b1) : acc_step;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    state_d  = StRun;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, rs_mag};
                    mplier_d = rt_mag;
                    acc_d    = '0;
                    neg_d    = rs_neg ^ rt_neg;
                end
            end
            StRun: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                // Final iteration folds straight into HI/LO so DONE sees the product.
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cnt_d   = '0;
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        hi   = hi_q;
        lo   = lo_q;
        busy = (state_q == StRun);
        done = (state_q == StDone);
        stall = busy && ((regsel_EX == 2'd1) || (regsel_EX == 2'd2) || enhilo_EX);
        case (regsel_EX)
            2'd1:    writeback_data = hi_q;
            2'd2:    writeback_data = lo_q;
            default: writeback_data = alu_result;
        endcase
    end

endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand width and the width of the HI and LO registers.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 enhilo_EX  input  1  mult/multu request from the EX-stage control.
REQ-005 alu_op  input  4  EX operation code; 4'b0110 = signed multiply, 4'b0111 = unsigned multiply.
REQ-006 regsel_EX  input  2  writeback select: 1 = mfhi, 2 = mflo, 0 = ALU result, 3 treated as 0.
REQ-007 rs_data, rt_data  input  WIDTH each  multiplicand and multiplier.
REQ-008 alu_result  input  WIDTH  ALU output to pass through when regsel_EX selects the ALU.
REQ-009 writeback_data  output  WIDTH  selected writeback value.
REQ-010 hi, lo  output  WIDTH each  architectural HI and LO registers.
REQ-011 busy  output  1  high while a multiply is in progress.
REQ-012 done  output  1  one-cycle pulse when HI/LO take a new product.
REQ-013 stall  output  1  pipeline hold request.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE, enhilo_EX=1 SHALL latch rs_data, rt_data and signedness (alu_op==4'b0110) and move to RUN.
  - Any other alu_op value with enhilo_EX=1 SHALL be treated as unsigned.
REQ-016 RUN SHALL perform a radix-2 shift-add for exactly WIDTH cycles, then move to DONE.
  - A 6-bit iteration counter SHALL count from 0 to WIDTH-1.
REQ-017 Signed mode SHALL multiply the operand magnitudes as unsigned values.
  - The 2*WIDTH product SHALL be two's-complement negated when the operand signs differ.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and SHALL be representable without overflow.
REQ-018 On entry to DONE, hi SHALL equal product[2*WIDTH-1:WIDTH] and lo SHALL equal product[WIDTH-1:0].
  - done SHALL be 1 for that single cycle.
  - The FSM SHALL return to IDLE on the next edge.
REQ-019 Latency: a request accepted at edge 0 SHALL update hi/lo at edge WIDTH+1.
  - busy SHALL be 1 from edge 1 through edge WIDTH inclusive.
REQ-020 hi and lo SHALL change only on the DONE transition or on reset.
REQ-021 writeback_data SHALL be combinational:
  - hi when regsel_EX==1; lo when regsel_EX==2; otherwise alu_result.
REQ-022 stall SHALL be asserted combinationally while busy=1 and either condition holds:
  - regsel_EX is 1 or 2;
  - enhilo_EX is 1.
REQ-023 enhilo_EX asserted while busy SHALL be ignored; the operation in progress SHALL continue unaffected.
REQ-024 Simultaneous enhilo_EX and regsel_EX=1/2 in IDLE SHALL return the pre-multiply hi/lo value with stall=0.
REQ-025 In DONE, writeback_data SHALL already reflect the new hi/lo, and stall SHALL be 0.
REQ-026 A new request in the DONE cycle SHALL be accepted as if the FSM were in IDLE.

Reset
REQ-027 rst=0 SHALL immediately force the following, regardless of state:
  - FSM = IDLE; hi = lo = 0; busy = done = 0; counter and operand/accumulator registers = 0.
REQ-028 Reset mid-RUN SHALL abort the multiply with no done pulse; the partial product SHALL never reach hi/lo.
REQ-029 After rst returns high, the first rising edge with enhilo_EX=1 SHALL start a multiply normally.

Verification
REQ-030 Reset: assert rst=0 with alu_result=0x12345678, regsel_EX=0.
  - Required: hi=lo=0, busy=0, done=0, stall=0, writeback_data=0x12345678.
REQ-031 Unsigned multiply: alu_op=0111, rs_data=rt_data=0xFFFFFFFF.
  - Required: busy high for 32 cycles, done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 Signed multiply: alu_op=0110, rs_data=0xFFFFFFFD (-3), rt_data=5.
  - Required: hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 Signed boundary: alu_op=0110, rs_data=rt_data=0x80000000.
  - Required: hi=0x40000000, lo=0x00000000.
REQ-034 Hazard: regsel_EX=2 while busy, plus a second enhilo_EX pulse at cycle 5.
  - Required: stall=1 until DONE; the second request is ignored.
  - Required: writeback_data equals the new lo in the DONE cycle.
REQ-035 Abort: pull rst low at RUN cycle 10.
  - Required: busy=0, hi=lo=0, no done pulse.
  - Required: a subsequent 7*6 unsigned multiply yields hi=0, lo=42.
